// File: rtl/dac_spi_multi.sv
// Multi-channel SPI driver for the LTC2624 quad DAC: latches one sample per channel
// on a strobe and shifts one 32-bit command frame per channel, channel 0 first.
module dac_spi_multi #(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_WIDTH   = 12,
   parameter int SCK_DIV      = 2,
   parameter int CS_GAP       = 2,
   parameter int UPDATE_MODE  = 0,
   parameter int CLR_HOLD     = 16
) (
   input  logic                               CLK_50MHZ,
   input  logic                               IN_RESET,
   input  logic                               IN_SAMPLE_STROBE,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] IN_SAMPLES,
   output logic                               OUT_BUSY,
   output logic                               OUT_DONE,
   output logic                               OUT_OVERRUN,
   output logic                               OUT_SPI_SCK,
   output logic                               OUT_SPI_MOSI,
   output logic                               OUT_DAC_CS,
   output logic                               OUT_DAC_CLR
);

   localparam int CNT_MAX = (CLR_HOLD > SCK_DIV)
                            ? ((CLR_HOLD > CS_GAP) ? CLR_HOLD : CS_GAP)
                            : ((SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SMP_W   = NUM_CHANNELS * DATA_WIDTH;

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         half_q, half_d;
   logic [1:0]         idx_q, idx_d;
   logic [SMP_W-1:0]   hold_q, hold_d;
   logic [31:0]        sr_q, sr_d;
   logic               done_d, overrun_d;

   function automatic logic [31:0] make_frame(input logic [SMP_W-1:0] s, input logic [1:0] ch);
      logic [DATA_WIDTH-1:0] smp;
      logic [11:0]           data;
      logic [3:0]            cmd;
      smp  = s[int'(ch)*DATA_WIDTH +: DATA_WIDTH];
      data = 12'(smp) << (12 - DATA_WIDTH);
      if (UPDATE_MODE == 0)
         cmd = 4'b0011;
      else if (ch == 2'(NUM_CHANNELS - 1))
         cmd = 4'b0010;
      else
         cmd = 4'b0000;
      return {8'h00, cmd, 2'b00, ch, data, 4'h0};
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      sr_d      = sr_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == CNT_W'(CLR_HOLD - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (IN_SAMPLE_STROBE) begin
               hold_d  = IN_SAMPLES;
               idx_d   = 2'd0;
               half_d  = 6'd0;
               cnt_d   = '0;
               sr_d    = make_frame(IN_SAMPLES, 2'd0);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            overrun_d = IN_SAMPLE_STROBE;
            // half_q counts SCK half-periods; odd halves are SCK high, MOSI moves on falling edges
            if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
               cnt_d = '0;
               if (half_q == 6'd63) begin
                  state_d = ST_GAP;
               end else begin
                  half_d = half_q + 6'd1;
                  if (half_q[0])
                     sr_d = {sr_q[30:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            overrun_d = IN_SAMPLE_STROBE;
            if (cnt_q == CNT_W'(CS_GAP - 1)) begin
               cnt_d = '0;
               if (idx_q == 2'(NUM_CHANNELS - 1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  half_d  = 6'd0;
                  sr_d    = make_frame(hold_q, idx_q + 2'd1);
                  state_d = ST_SHIFT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Outputs are registered from next-state values so they change together with the state.
   always_ff @(posedge CLK_50MHZ) begin
      if (IN_RESET) begin
         state_q      <= ST_CLEAR;
         cnt_q        <= '0;
         OUT_SPI_SCK  <= 1'b0;
         OUT_SPI_MOSI <= 1'b0;
         OUT_DAC_CS   <= 1'b1;
         OUT_DAC_CLR  <= 1'b0;
         OUT_BUSY     <= 1'b1;
         OUT_DONE     <= 1'b0;
         OUT_OVERRUN  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         OUT_SPI_SCK  <= (state_d == ST_SHIFT) && half_d[0];
         OUT_SPI_MOSI <= (state_d == ST_SHIFT) && sr_d[31];
         OUT_DAC_CS   <= (state_d != ST_SHIFT);
         OUT_DAC_CLR  <= (state_d != ST_CLEAR);
         OUT_BUSY     <= (state_d != ST_IDLE);
         OUT_DONE     <= done_d;
         OUT_OVERRUN  <= overrun_d;
      end
   end

   // NOTE: datapath registers are deliberately not reset; they are always loaded before use.
   always_ff @(posedge CLK_50MHZ) begin
      half_q <= half_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
      sr_q   <= sr_d;
   end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Self-checking bench for dac_spi_multi: two differently parameterised instances,
// a negedge SPI monitor, and a frame/timing model computed from the DAC command format.
module tb_dac_spi_multi;

   localparam int A_C = 2, A_DW = 8,  A_SDIV = 2, A_GAP = 2, A_MODE = 1, A_CLR = 16;
   localparam int B_C = 4, B_DW = 12, B_SDIV = 1, B_GAP = 3, B_MODE = 0, B_CLR = 5;

   localparam int CH   [2] = '{A_C, B_C};
   localparam int DW   [2] = '{A_DW, B_DW};
   localparam int SDIV [2] = '{A_SDIV, B_SDIV};
   localparam int GAP  [2] = '{A_GAP, B_GAP};
   localparam int MODE [2] = '{A_MODE, B_MODE};

   logic        clk = 1'b0;
   logic [1:0]  rst, strobe, busy, done, ovr, sck, mosi, cs, clr;
   logic [47:0] samples [2];
   int          cyc = 0, nvec = 0, nerr = 0;

   // monitor records
   logic [31:0] cap_word [2][64];
   int          cap_bits [2][64], cap_low [2][64], cap_gap [2][64];
   int          done_at  [2][64], ovr_at [2][64];
   int          cap_n [2] = '{0, 0}, done_n [2] = '{0, 0}, ovr_n [2] = '{0, 0};
   logic [31:0] acc [2] = '{32'd0, 32'd0};
   int          bits [2] = '{0, 0}, lowcnt [2] = '{0, 0}, hicnt [2] = '{0, 0};
   logic [1:0]  prev_cs = 2'b11, prev_sck = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac_spi_multi #(
      .NUM_CHANNELS(A_C), .DATA_WIDTH(A_DW), .SCK_DIV(A_SDIV),
      .CS_GAP(A_GAP), .UPDATE_MODE(A_MODE), .CLR_HOLD(A_CLR)
   ) dut_a (
      .CLK_50MHZ(clk), .IN_RESET(rst[0]), .IN_SAMPLE_STROBE(strobe[0]),
      .IN_SAMPLES(samples[0][A_C*A_DW-1:0]),
      .OUT_BUSY(busy[0]), .OUT_DONE(done[0]), .OUT_OVERRUN(ovr[0]),
      .OUT_SPI_SCK(sck[0]), .OUT_SPI_MOSI(mosi[0]), .OUT_DAC_CS(cs[0]), .OUT_DAC_CLR(clr[0])
   );

   dac_spi_multi #(
      .NUM_CHANNELS(B_C), .DATA_WIDTH(B_DW), .SCK_DIV(B_SDIV),
      .CS_GAP(B_GAP), .UPDATE_MODE(B_MODE), .CLR_HOLD(B_CLR)
   ) dut_b (
      .CLK_50MHZ(clk), .IN_RESET(rst[1]), .IN_SAMPLE_STROBE(strobe[1]),
      .IN_SAMPLES(samples[1][B_C*B_DW-1:0]),
      .OUT_BUSY(busy[1]), .OUT_DONE(done[1]), .OUT_OVERRUN(ovr[1]),
      .OUT_SPI_SCK(sck[1]), .OUT_SPI_MOSI(mosi[1]), .OUT_DAC_CS(cs[1]), .OUT_DAC_CLR(clr[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nvec++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference frame: 0x00 | cmd<<20 | addr<<16 | sample left-justified in bits [15:4]
   function automatic logic [31:0] exp_frame(input int u, input int ch, input logic [47:0] s);
      longint sv, smp, cmd;
      sv  = longint'(s);
      smp = (sv >> (ch * DW[u])) & ((64'sd1 << DW[u]) - 1);
      if (MODE[u] == 0)           cmd = 3;
      else if (ch == CH[u] - 1)   cmd = 2;
      else                        cmd = 0;
      return 32'(cmd * (1 << 20) + ch * (1 << 16) + smp * (1 << (16 - DW[u])));
   endfunction

   function automatic int lat(input int u);
      return CH[u] * (64 * SDIV[u] + GAP[u]) + 1;
   endfunction

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (done[u] === 1'b1) begin
            if (done_n[u] < 64) done_at[u][done_n[u]] = cyc;
            done_n[u]++;
         end
         if (ovr[u] === 1'b1) begin
            if (ovr_n[u] < 64) ovr_at[u][ovr_n[u]] = cyc;
            ovr_n[u]++;
         end
         if (cs[u] === 1'b0) begin
            if (prev_cs[u] && cap_n[u] < 64) cap_gap[u][cap_n[u]] = hicnt[u];
            lowcnt[u]++;
            if (sck[u] && !prev_sck[u]) begin
               acc[u] = {acc[u][30:0], mosi[u]};
               bits[u]++;
            end
         end else begin
            if (!prev_cs[u]) begin
               if (cap_n[u] < 64) begin
                  cap_word[u][cap_n[u]] = acc[u];
                  cap_bits[u][cap_n[u]] = bits[u];
                  cap_low[u][cap_n[u]]  = lowcnt[u];
               end
               cap_n[u]++;
               acc[u] = 32'd0; bits[u] = 0; lowcnt[u] = 0; hicnt[u] = 1;
            end else begin
               hicnt[u]++;
            end
            check($sformatf("u%0d_mosi_cs_high", u), 32'(mosi[u]), 32'd0);
            check($sformatf("u%0d_sck_cs_high", u), 32'(sck[u]), 32'd0);
         end
         prev_cs[u]  = cs[u];
         prev_sck[u] = sck[u];
      end
   end

   task automatic strobe_at(input int u, input logic [47:0] s, input int target, output int n);
      while (cyc < target) @(negedge clk);
      strobe[u]  = 1'b1;
      samples[u] = s;
      n = cyc;
      @(negedge clk);
      strobe[u]  = 1'b0;
      samples[u] = 48'({$urandom(), $urandom()});
   endtask

   task automatic wait_done(input int u, input int want);
      int t = 0;
      while (done_n[u] < want && t < 4000) begin
         @(negedge clk); #1;
         t++;
      end
      check($sformatf("u%0d_done_timeout", u), 32'(done_n[u] >= want), 32'd1);
   endtask

   task automatic verify(input int u, input logic [47:0] s, input int n, input int fb, input int db);
      check($sformatf("u%0d_done_cycle", u), 32'(done_at[u][db]), 32'(n + lat(u)));
      for (int k = 0; k < CH[u]; k++) begin
         check($sformatf("u%0d_frame%0d_word", u, k), cap_word[u][fb+k], exp_frame(u, k, s));
         check($sformatf("u%0d_frame%0d_sck_rises", u, k), 32'(cap_bits[u][fb+k]), 32'd32);
         check($sformatf("u%0d_frame%0d_cs_low", u, k), 32'(cap_low[u][fb+k]), 32'(64 * SDIV[u]));
         if (k > 0)
            check($sformatf("u%0d_frame%0d_gap", u, k), 32'(cap_gap[u][fb+k]), 32'(GAP[u]));
      end
   endtask

   task automatic transfer(input int u, input logic [47:0] s);
      int n, fb, db;
      fb = cap_n[u]; db = done_n[u];
      strobe_at(u, s, cyc + 1, n);
      wait_done(u, db + 1);
      check($sformatf("u%0d_frame_count", u), 32'(cap_n[u]), 32'(fb + CH[u]));
      verify(u, s, n, fb, db);
   endtask

   initial begin
      logic [47:0] s1, s2, s3, sb [3];
      int n1, n2, n3, m [3], fb, db, ob, r_cyc;

      rst = 2'b11; strobe = 2'b00;
      samples[0] = '0; samples[1] = '0;
      repeat (5) @(negedge clk);

      // reset / CLEAR sequencing, strobe during CLEAR ignored
      r_cyc = cyc;
      @(negedge clk);
      rst = 2'b00;
      for (int c = 1; c <= A_CLR + 1; c++) begin
         if (c > 1) @(negedge clk);
         strobe = (c == 3) ? 2'b11 : 2'b00;
         check("clear_cycle", 32'(cyc), 32'(r_cyc + c));
         check("u0_clr", 32'(clr[0]), 32'(c >= A_CLR + 1));
         check("u0_busy", 32'(busy[0]), 32'(c < A_CLR + 1));
         check("u1_clr", 32'(clr[1]), 32'(c >= B_CLR + 1));
         check("u1_busy", 32'(busy[1]), 32'(c < B_CLR + 1));
         check("u0_cs_clear", 32'(cs[0]), 32'd1);
         check("u1_cs_clear", 32'(cs[1]), 32'd1);
      end
      strobe = 2'b00;
      repeat (3) @(negedge clk);
      check("u0_no_overrun_clear", 32'(ovr_n[0]), 32'd0);
      check("u1_no_overrun_clear", 32'(ovr_n[1]), 32'd0);
      check("u0_no_frame_clear", 32'(cap_n[0]), 32'd0);
      check("u1_no_frame_clear", 32'(cap_n[1]), 32'd0);

      // directed frames, then randomized ones
      transfer(0, 48'h0000_0000_F012);
      transfer(1, 48'h1234_5678_9ABC);
      for (int r = 0; r < 3; r++) transfer(0, 48'({$urandom(), $urandom()}));
      for (int r = 0; r < 2; r++) transfer(1, 48'({$urandom(), $urandom()}));

      // overrun 10 cycles in, then a strobe in the DONE cycle
      s1 = 48'({$urandom(), $urandom()});
      s2 = ~s1;
      s3 = 48'({$urandom(), $urandom()});
      fb = cap_n[0]; db = done_n[0]; ob = ovr_n[0];
      strobe_at(0, s1, cyc + 1, n1);
      strobe_at(0, s2, n1 + 10, n2);
      strobe_at(0, s3, n1 + lat(0), n3);
      wait_done(0, db + 2);
      check("u0_overrun_count", 32'(ovr_n[0]), 32'(ob + 1));
      check("u0_overrun_cycle", 32'(ovr_at[0][ob]), 32'(n2 + 1));
      check("u0_done_count_ovr", 32'(done_n[0]), 32'(db + 2));
      check("u0_frames_ovr", 32'(cap_n[0]), 32'(fb + 2 * A_C));
      verify(0, s1, n1, fb, db);
      verify(0, s3, n3, fb + A_C, db + 1);

      // reset in the middle of bit 17 of frame 0
      db = done_n[0];
      strobe_at(0, 48'({$urandom(), $urandom()}), cyc + 1, n1);
      while (cyc < n1 + 70) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      check("rst_cs", 32'(cs[0]), 32'd1);
      check("rst_sck", 32'(sck[0]), 32'd0);
      check("rst_mosi", 32'(mosi[0]), 32'd0);
      check("rst_clr", 32'(clr[0]), 32'd0);
      check("rst_busy", 32'(busy[0]), 32'd1);
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (300) @(negedge clk);
      check("rst_no_done", 32'(done_n[0]), 32'(db));
      check("rst_clr_release", 32'(clr[0]), 32'd1);
      check("rst_busy_release", 32'(busy[0]), 32'd0);
      transfer(0, 48'({$urandom(), $urandom()}));

      // SCK_DIV=1 back-to-back strobes on DONE cycles
      fb = cap_n[1]; db = done_n[1]; ob = ovr_n[1];
      for (int j = 0; j < 3; j++) sb[j] = 48'({$urandom(), $urandom()});
      strobe_at(1, sb[0], cyc + 1, m[0]);
      strobe_at(1, sb[1], m[0] + lat(1), m[1]);
      strobe_at(1, sb[2], m[1] + lat(1), m[2]);
      wait_done(1, db + 3);
      check("u1_b2b_done_count", 32'(done_n[1]), 32'(db + 3));
      check("u1_b2b_frames", 32'(cap_n[1]), 32'(fb + 3 * B_C));
      check("u1_b2b_no_overrun", 32'(ovr_n[1]), 32'(ob));
      for (int j = 0; j < 3; j++) verify(1, sb[j], m[j], fb + j * B_C, db + j);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dac_spi_multi.md
# dac_spi_multi

Parametrised multi-channel SPI driver for the on-board LTC2624 quad 12-bit DAC. It is the successor to the single-channel DAC output stage. It latches one sample per channel on a strobe from the synth sample pipeline and shifts one 32-bit LTC2624 command frame per channel, channel 0 first. It adds selectable per-channel or simultaneous output update, DAC clear sequencing after reset, and busy/done/overrun handshake flags.

## Interface
- NUM_CHANNELS, 4, channels driven per strobe (1–4); channel i uses DAC address i.
- DATA_WIDTH, 12, sample width (1–12); left-justified into the 12-bit data field, LSBs zero-padded.
- SCK_DIV, 2, SCK half-period in clock cycles (≥1); SCK period = 2·SCK_DIV clocks.
- CS_GAP, 2, clock cycles OUT_DAC_CS stays high after every frame (≥1).
- UPDATE_MODE, 0, 0 = every frame uses command 0011 (write and update channel n); 1 = frames before the last use command 0000 (write input register n), and the last frame uses 0010 (write n, update all).
- CLR_HOLD, 16, clock cycles OUT_DAC_CLR stays low after reset is released.
- CLK_50MHZ  in  1  system clock; all logic on rising edge.
- IN_RESET  in  1  reset, synchronous, active-high.
- IN_SAMPLE_STROBE  in  1  one-cycle request to send IN_SAMPLES.
- IN_SAMPLES  in  NUM_CHANNELS·DATA_WIDTH  channel i at bits [i·DATA_WIDTH +: DATA_WIDTH].
- OUT_BUSY  out  1  high while clearing or transmitting.
- OUT_DONE  out  1  one-cycle pulse when a strobe's full frame set is complete.
- OUT_OVERRUN  out  1  one-cycle pulse when a strobe is rejected.
- OUT_SPI_SCK  out  1  SPI clock; idles low.
- OUT_SPI_MOSI  out  1  SPI data, MSB first.
- OUT_DAC_CS  out  1  DAC chip select, active low.
- OUT_DAC_CLR  out  1  DAC asynchronous clear, active low.

## Operation
- Frame format, bit 31 first:
  - [31:24] = 0x00
  - [23:20] = command
  - [19:16] = channel address
  - [15:4] = data
  - [3:0] = 0
- States:
  - CLEAR: entered on reset. OUT_DAC_CLR is low, OUT_BUSY is high, and strobes are ignored with no overrun. After CLR_HOLD cycles following reset release, the block goes to IDLE.
  - IDLE: OUT_BUSY is low. A strobe latches every channel of IN_SAMPLES into a holding register, sets channel index 0, and moves to SHIFT.
  - SHIFT: CS is low for 32 bits. After the last bit the block moves to GAP.
  - GAP: CS is high for CS_GAP cycles. Then, if the index is below NUM_CHANNELS−1, the index increments and the block returns to SHIFT; otherwise it goes to IDLE and pulses OUT_DONE.
- IN_SAMPLES is sampled only in the accepting cycle; changes during transmission have no effect.
- A strobe while OUT_BUSY is high (outside CLEAR) pulses OUT_OVERRUN the next cycle. The samples are dropped and the transfer in progress is unaffected.
- Reset at any point, including mid-frame, takes effect the next cycle: the block enters CLEAR, the frame is aborted, and the holding register contents become don't-care.
- Reset values:
  - OUT_SPI_SCK = 0, OUT_SPI_MOSI = 0
  - OUT_DAC_CS = 1, OUT_DAC_CLR = 0
  - OUT_BUSY = 1
  - OUT_DONE = 0, OUT_OVERRUN = 0

## Timing
- All outputs are registered. F = 64·SCK_DIV, G = CS_GAP, C = NUM_CHANNELS.
- A strobe accepted in cycle N gives:
  - OUT_BUSY = 1 from cycle N+1.
  - Frame k (k = 0..C−1): CS low for cycles N+1+k(F+G) through N+k(F+G)+F, then high for G cycles.
- Within a frame:
  - MOSI presents bit 31 in the first CS-low cycle.
  - SCK rises after SCK_DIV cycles; the DAC samples on this edge.
  - SCK falls SCK_DIV cycles later, and MOSI advances to the next bit in the same cycle.
  - After the 32nd falling edge, SCK stays low and CS rises.
- MOSI returns to 0 when CS is high.
- Completion: OUT_DONE = 1 and OUT_BUSY = 0 in cycle N+C(F+G)+1. A strobe in that same cycle is accepted.
- CLEAR duration: with IN_RESET high through cycle R, OUT_DAC_CLR goes high and OUT_BUSY goes low in cycle R+CLR_HOLD+1.

## Test plan
- **Reset/clear:** C=2, SCK_DIV=2, G=2, CLR_HOLD=16; hold reset 5 cycles, release → CLR low through 16 cycles after release, then CLR=1 and BUSY=0. CS=1 and SCK=0 throughout; a strobe during CLEAR gives no OVERRUN.
- **Single channel, UPDATE_MODE=0:** C=1, samples 0xABC → one frame with MOSI stream 0x0030ABC0, exactly 32 SCK rising edges, CS low for 128 cycles. DONE at strobe+131.
- **Two channels, UPDATE_MODE=1, DATA_WIDTH=8:** samples ch0=0x12, ch1=0xF0 → frames 0x00001200 then 0x0021F000, separated by a 2-cycle CS-high gap. DONE pulses once.
- **Overrun:** strobe, then a second strobe 10 cycles later → OVERRUN pulses one cycle. Frames carry only the first sample set; a strobe in the DONE cycle starts a new transfer immediately.
- **Mid-frame reset:** assert reset at bit 17 of frame 0 → next cycle CS=1, SCK=0, MOSI=0, CLR=0, BUSY=1, and no DONE. After CLEAR completes, a new strobe produces a correct full frame.
- **SCK_DIV=1 stress:** C=4, back-to-back strobes issued on the DONE cycles → 4 frames each at 64 cycles plus gap, addresses 0..3 in order, and no OVERRUN.
